block_read_scheduler: RTL and testbench

BLOCK_READ_SCHEDULER -- requirements
Module: block_read_scheduler

---
 rtl/block_read_scheduler.sv | 75 +++++++
 tb/tb_block_read_scheduler.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/block_read_scheduler.sv
// block_read_scheduler: round-robin arbiter that runs one full NUM_BLOCKS read pass per grant
module block_read_scheduler #(
  parameter int REGISTER_SIZE = 32,
  parameter int NUM_BLOCKS = 128,
  localparam int IDXW = $clog2(NUM_BLOCKS)
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic                     req_a_in,
  input  logic                     req_b_in,
  output logic                     grant_a_out,
  output logic                     grant_b_out,
  input  logic                     stall_in,
  output logic                     read_next_out,
  input  logic [REGISTER_SIZE-1:0] read_block_in,
  input  logic                     read_valid_in,
  output logic [REGISTER_SIZE-1:0] block_out,
  output logic                     block_valid_out,
  output logic [IDXW-1:0]          block_index_out,
  output logic                     block_last_out,
  output logic                     done_a_out,
  output logic                     done_b_out,
  output logic                     busy_out
);
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;
  localparam logic [IDXW-1:0] LAST = IDXW'(NUM_BLOCKS - 1);
  state_t          state_q;
  logic            grant_a_q, grant_b_q, ptr_b_q, win_b_d, run;
  logic [IDXW-1:0] iss_q, rx_q;
  assign run             = !rst_in;
  assign win_b_d         = req_b_in && (!req_a_in || ptr_b_q);
  assign busy_out        = run && state_q != IDLE;
  assign read_next_out   = run && state_q == ISSUE && !stall_in;
  assign grant_a_out     = run && grant_a_q;
  assign grant_b_out     = run && grant_b_q;
  assign done_a_out      = run && state_q == DONE && grant_a_q;
  assign done_b_out      = run && state_q == DONE && grant_b_q;
  assign block_out       = read_block_in;
  assign block_valid_out = read_valid_in && busy_out;
  assign block_index_out = run ? rx_q : '0;
  assign block_last_out  = block_valid_out && rx_q == LAST;
  // pass sequencing: grant latch, issue/receive counting, pointer rotation on completion
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q   <= IDLE;
      grant_a_q <= 1'b0;
      grant_b_q <= 1'b0;
      ptr_b_q   <= 1'b0;
      iss_q     <= '0;
      rx_q      <= '0;
    end else begin
      if (block_valid_out) rx_q <= rx_q + IDXW'(1);
      case (state_q)
        IDLE: if (req_a_in || req_b_in) begin
          state_q   <= ISSUE;
          grant_a_q <= !win_b_d;
          grant_b_q <= win_b_d;
        end
        ISSUE: if (read_next_out) begin
          iss_q <= iss_q + IDXW'(1);
          if (iss_q == LAST) state_q <= DRAIN;
        end
        DRAIN: if (block_last_out) state_q <= DONE;
        DONE: begin
          state_q   <= IDLE;
          grant_a_q <= 1'b0;
          grant_b_q <= 1'b0;
          ptr_b_q   <= grant_a_q;
          iss_q     <= '0;
          rx_q      <= '0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_block_read_scheduler.sv
// tb_block_read_scheduler: table-driven single pass plus directed stall, contention, drop and reset sequences
module tb_block_read_scheduler;
  localparam int N = 8, W = 32;
  typedef struct packed {
    logic [3:0] in;
    logic [3:0] o1;
    logic [2:0] idx;
    logic [3:0] o2;
  } vec_t;
  logic clk_in = 1'b0, rst_in = 1'b1, req_a_in = 1'b0, req_b_in = 1'b0, stall_in = 1'b0;
  logic grant_a_out, grant_b_out, read_next_out, block_valid_out, block_last_out;
  logic done_a_out, done_b_out, busy_out;
  logic [W-1:0] read_block_in, block_out;
  logic read_valid_in;
  logic [2:0] block_index_out;
  int checks = 0, failures = 0;
  int m_strobes = 0, m_beats = 0;
  vec_t tv [14];
  logic [2:0] addr_q;
  logic v1, v2;
  logic [W-1:0] d1, d2;
  logic da, db;
  block_read_scheduler #(.REGISTER_SIZE(W), .NUM_BLOCKS(N)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .req_a_in(req_a_in), .req_b_in(req_b_in),
    .grant_a_out(grant_a_out), .grant_b_out(grant_b_out), .stall_in(stall_in),
    .read_next_out(read_next_out), .read_block_in(read_block_in), .read_valid_in(read_valid_in),
    .block_out(block_out), .block_valid_out(block_valid_out), .block_index_out(block_index_out),
    .block_last_out(block_last_out), .done_a_out(done_a_out), .done_b_out(done_b_out),
    .busy_out(busy_out)
  );
  always #5 clk_in = ~clk_in;
  function automatic logic [W-1:0] data_of(input logic [2:0] a);
    return 32'hC0DE_0000 | {29'd0, a};
  endfunction
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask
  function automatic logic [10:0] outs();
    return {grant_a_out, grant_b_out, read_next_out, block_valid_out, block_index_out,
            block_last_out, done_a_out, done_b_out, busy_out};
  endfunction
  task automatic wait_done(output logic a, output logic b);
    a = 1'b0;
    b = 1'b0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk_in);
      if (done_a_out || done_b_out) begin
        a = done_a_out;
        b = done_b_out;
        break;
      end
    end
    chk("done_seen", {63'd0, a | b}, 64'd1);
  endtask
  // block store: address advances per strobe, data and valid appear two cycles later
  always @(posedge clk_in) begin
    if (rst_in) begin
      addr_q <= '0; v1 <= 1'b0; v2 <= 1'b0; d1 <= '0; d2 <= '0;
    end else begin
      v1 <= read_next_out;
      d1 <= data_of(addr_q);
      v2 <= v1;
      d2 <= d1;
      if (read_next_out) addr_q <= addr_q + 3'd1;
    end
  end
  assign read_valid_in = v2;
  assign read_block_in = d2;
  // invariants and per-beat stream checks for every pass
  always @(negedge clk_in) begin
    if (rst_in) begin
      m_strobes = 0;
      m_beats = 0;
    end else begin
      chk("grant_onehot", {63'd0, grant_a_out & grant_b_out}, 64'd0);
      if (read_next_out) begin
        chk("rn_needs_grant", {63'd0, grant_a_out | grant_b_out}, 64'd1);
        m_strobes++;
      end
      if (block_valid_out) begin
        chk("beat_index", {61'd0, block_index_out}, {61'd0, 3'(m_beats)});
        chk("beat_data", {32'd0, block_out}, {32'd0, data_of(3'(m_beats))});
        chk("beat_last", {63'd0, block_last_out}, {63'd0, m_beats == N - 1});
        m_beats++;
      end
      if (done_a_out || done_b_out) begin
        chk("pass_strobes", 64'(m_strobes), 64'(N));
        chk("pass_beats", 64'(m_beats), 64'(N));
        m_strobes = 0;
        m_beats = 0;
      end
    end
  end
  initial begin
    tv[0]  = {4'b1000, 4'b0000, 3'd0, 4'b0000};
    tv[1]  = {4'b0100, 4'b0000, 3'd0, 4'b0000};
    tv[2]  = {4'b0000, 4'b1010, 3'd0, 4'b0001};
    tv[3]  = {4'b0000, 4'b1010, 3'd0, 4'b0001};
    for (int k = 0; k < 6; k++) tv[4 + k] = {4'b0000, 4'b1011, 3'(k), 4'b0001};
    tv[10] = {4'b0000, 4'b1001, 3'd6, 4'b0001};
    tv[11] = {4'b0000, 4'b1001, 3'd7, 4'b1001};
    tv[12] = {4'b0000, 4'b1000, 3'd0, 4'b0101};
    tv[13] = {4'b0000, 4'b0000, 3'd0, 4'b0000};
    repeat (2) @(posedge clk_in);
    for (int i = 0; i < 14; i++) begin
      @(posedge clk_in);
      #1 {rst_in, req_a_in, req_b_in, stall_in} = tv[i].in;
      @(negedge clk_in);
      chk($sformatf("vec%0d", i), {53'd0, outs()}, {53'd0, tv[i].o1, tv[i].idx, tv[i].o2});
    end
    @(posedge clk_in);
    #1 req_a_in = 1'b1;
    @(negedge clk_in);
    for (int c = 1; c <= 5; c++) begin
      @(posedge clk_in);
      #1 req_a_in = 1'b0;
      stall_in = c >= 3;
      @(negedge clk_in);
      chk($sformatf("stall_rn%0d", c), {63'd0, read_next_out}, {63'd0, c < 3});
      chk($sformatf("stall_inflight%0d", c), {63'd0, block_valid_out}, {63'd0, c == 3 || c == 4});
    end
    @(posedge clk_in);
    #1 stall_in = 1'b0;
    wait_done(da, db);
    chk("stall_done", {62'd0, da, db}, 64'b10);
    @(negedge clk_in);
    chk("stall_idle_after", {63'd0, busy_out}, 64'd0);
    @(posedge clk_in);
    #1 rst_in = 1'b1;
    @(posedge clk_in);
    #1 rst_in = 1'b0;
    req_a_in = 1'b1;
    req_b_in = 1'b1;
    for (int p = 0; p < 4; p++) begin
      wait_done(da, db);
      chk($sformatf("order%0d", p), {62'd0, da, db}, (p % 2 == 0) ? 64'b10 : 64'b01);
      if (p < 3) begin
        @(negedge clk_in);
        chk("gap_idle", {61'd0, busy_out, grant_a_out, grant_b_out}, 64'd0);
        @(negedge clk_in);
        chk("next_grant", {62'd0, grant_a_out, grant_b_out}, (p % 2 == 0) ? 64'b01 : 64'b10);
      end else begin
        @(posedge clk_in);
        #1 req_a_in = 1'b0;
        req_b_in = 1'b0;
      end
    end
    @(posedge clk_in);
    #1 req_b_in = 1'b1;
    @(posedge clk_in);
    #1 req_b_in = 1'b0;
    wait_done(da, db);
    chk("drop_done_b", {62'd0, da, db}, 64'b01);
    @(posedge clk_in);
    #1 req_a_in = 1'b1;
    @(posedge clk_in);
    #1 req_a_in = 1'b0;
    repeat (4) @(posedge clk_in);
    #1 rst_in = 1'b1;
    @(negedge clk_in);
    chk("rst_outs", {53'd0, outs()}, 64'd0);
    @(posedge clk_in);
    #1 rst_in = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk_in);
      chk("post_rst_quiet", {53'd0, outs()}, 64'd0);
    end
    @(posedge clk_in);
    #1 req_a_in = 1'b1;
    @(posedge clk_in);
    #1 req_a_in = 1'b0;
    wait_done(da, db);
    chk("rst_rerun_done_a", {62'd0, da, db}, 64'b10);
    @(negedge clk_in);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
